// File: rtl/ovo_svm_sequencer.sv
// One-vs-one multiclass sequencer for a shared, time-multiplexed binary SVM engine.
// Latches one feature vector, walks every class pair (i<j) in lexicographic order,
// tallies one vote per pair and returns the arg-max class (ties -> lowest index).
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data   feature vector handshake (accepted only in IDLE)
//   svm_start/svm_pair_idx      one-cycle evaluate pulse and current pair index
//   svm_inputs                  latched feature vector, stable for the inference
//   svm_done/svm_class          engine result pulse; 1 = first class of pair wins
//   out_valid/out_ready         result handshake
//   out_class/out_votes         winning class and its vote count
module ovo_svm_sequencer #(
    parameter int N_CLASSES  = 7,
    parameter int N_FEATURES = 11,
    parameter int IN_W       = 4,
    localparam int P  = N_CLASSES * (N_CLASSES - 1) / 2,
    localparam int PW = (P > 1) ? $clog2(P) : 1,
    localparam int CW = $clog2(N_CLASSES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W*N_FEATURES-1:0] in_data,
    output logic                       svm_start,
    output logic [PW-1:0]              svm_pair_idx,
    output logic [IN_W*N_FEATURES-1:0] svm_inputs,
    input  logic                       svm_done,
    input  logic                       svm_class,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CW-1:0]              out_class,
    output logic [CW-1:0]              out_votes
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ARGMAX,
        RESULT
    } state_t;

    state_t                     state_q;
    logic                       in_ready_q;
    logic                       svm_start_q;
    logic [PW-1:0]              pair_q;
    logic [IN_W*N_FEATURES-1:0] inputs_q;
    logic                       out_valid_q;
    logic [CW-1:0]              out_class_q;
    logic [CW-1:0]              out_votes_q;
    logic [CW-1:0]              i_q;
    logic [CW-1:0]              j_q;
    logic [CW-1:0]              votes_q [N_CLASSES];

    logic [CW-1:0]              win_idx_d;
    logic [CW-1:0]              best_cls_d;
    logic [CW-1:0]              best_votes_d;

    assign in_ready     = in_ready_q;
    assign svm_start    = svm_start_q;
    assign svm_pair_idx = pair_q;
    assign svm_inputs   = inputs_q;
    assign out_valid    = out_valid_q;
    assign out_class    = out_class_q;
    assign out_votes    = out_votes_q;

    always_comb begin
        win_idx_d    = svm_class ? i_q : j_q;
        best_cls_d   = '0;
        best_votes_d = votes_q[0];
        // Strict compare keeps the lowest class index on ties.
        for (int k = 1; k < N_CLASSES; k++) begin
            if (votes_q[k] > best_votes_d) begin
                best_votes_d = votes_q[k];
                best_cls_d   = CW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            svm_start_q <= 1'b0;
            pair_q      <= '0;
            inputs_q    <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_votes_q <= '0;
            i_q         <= '0;
            j_q         <= '0;
            for (int k = 0; k < N_CLASSES; k++) begin
                votes_q[k] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        inputs_q    <= in_data;
                        pair_q      <= '0;
                        i_q         <= '0;
                        j_q         <= CW'(1);
                        svm_start_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        state_q     <= ISSUE;
                        for (int k = 0; k < N_CLASSES; k++) begin
                            votes_q[k] <= '0;
                        end
                    end
                end
                ISSUE: begin
                    svm_start_q <= 1'b0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (svm_done) begin
                        votes_q[win_idx_d] <= votes_q[win_idx_d] + 1'b1;
                        if (pair_q == PW'(P - 1)) begin
                            state_q <= ARGMAX;
                        end else begin
                            pair_q <= pair_q + 1'b1;
                            // Row wrap: next pair starts at (i+1, i+2).
                            if (j_q == CW'(N_CLASSES - 1)) begin
                                i_q <= i_q + 1'b1;
                                j_q <= i_q + CW'(2);
                            end else begin
                                j_q <= j_q + 1'b1;
                            end
                            svm_start_q <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ARGMAX: begin
                    out_class_q <= best_cls_d;
                    out_votes_q <= best_votes_d;
                    out_valid_q <= 1'b1;
                    state_q     <= RESULT;
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ovo_svm_sequencer.sv
// Bench for ovo_svm_sequencer: N=7 and N=3 instances driven by a procedural
// engine model, checked against table constants and a pair-walk vote model.
module tb_ovo_svm_sequencer;

    localparam int DW = 44;

    logic          clk = 1'b0;
    logic          rst;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, svm_start, svm_done, svm_class;
    logic          out_valid, out_ready;
    logic [DW-1:0] in_data, svm_inputs;
    logic [4:0]    svm_pair_idx;
    logic [2:0]    out_class, out_votes;

    logic          in_valid3, in_ready3, svm_start3, svm_done3, svm_class3;
    logic          out_valid3, out_ready3;
    logic [DW-1:0] in_data3, svm_inputs3;
    logic [1:0]    svm_pair_idx3, out_class3, out_votes3;

    ovo_svm_sequencer #(.N_CLASSES(7), .N_FEATURES(11), .IN_W(4)) dut7 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .svm_start(svm_start), .svm_pair_idx(svm_pair_idx),
        .svm_inputs(svm_inputs), .svm_done(svm_done), .svm_class(svm_class),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_votes(out_votes)
    );

    ovo_svm_sequencer #(.N_CLASSES(3), .N_FEATURES(11), .IN_W(4)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .svm_start(svm_start3), .svm_pair_idx(svm_pair_idx3),
        .svm_inputs(svm_inputs3), .svm_done(svm_done3), .svm_class(svm_class3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_class(out_class3), .out_votes(out_votes3)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] last_data;

    typedef struct {
        logic [DW-1:0] data;
        logic [20:0]   dec;
        int            lat;
        int            hold;
        int            exp_cls;
        int            exp_votes;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: enumerate pairs i<j, give the vote, pick first maximum.
    function automatic void model(input logic [20:0] dec, input int n,
                                  output int cls, output int votes);
        int v[7];
        int p;
        p = 0;
        for (int k = 0; k < 7; k++) v[k] = 0;
        for (int i = 0; i < n; i++) begin
            for (int j = i + 1; j < n; j++) begin
                if (dec[p]) v[i]++;
                else v[j]++;
                p++;
            end
        end
        cls   = 0;
        votes = v[0];
        for (int k = 1; k < n; k++) begin
            if (v[k] > votes) begin
                votes = v[k];
                cls   = k;
            end
        end
    endfunction

    task automatic run7(input logic [DW-1:0] data, input logic [20:0] dec,
                        input int lat, input int hold, input int abort_p,
                        input int exp_cls, input int exp_votes);
        int n;
        int k;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("inputs_before_accept", svm_inputs, last_data);
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~data;
        n = 1;
        for (int p = 0; p < 21; p++) begin
            k = 0;
            while (!svm_start && k < 8) begin
                @(negedge clk);
                n++;
                k++;
            end
            if (!svm_start) begin
                chk("start_timeout", 0, 1);
                return;
            end
            chk("start_time", n, 1 + p * (lat + 1));
            chk("pair_idx", svm_pair_idx, p);
            if (p == 0) chk("svm_inputs_latched", svm_inputs, data);
            @(negedge clk);
            n++;
            if (p == 0) chk("start_pulse_width", svm_start, 0);
            if (p == abort_p) begin
                rst = 1'b1;
                @(negedge clk);
                rst       = 1'b0;
                last_data = '0;
                svm_done  = 1'b1;
                svm_class = 1'b1;
                chk("abort_in_ready", in_ready, 1);
                chk("abort_start", svm_start, 0);
                chk("abort_out_valid", out_valid, 0);
                chk("abort_inputs", svm_inputs, 0);
                @(negedge clk);
                svm_done = 1'b0;
                chk("late_done_in_ready", in_ready, 1);
                chk("late_done_start", svm_start, 0);
                return;
            end
            repeat (lat - 1) begin
                @(negedge clk);
                n++;
            end
            svm_done  = 1'b1;
            svm_class = dec[p];
            @(negedge clk);
            n++;
            svm_done = 1'b0;
        end
        last_data = data;
        k = 0;
        while (!out_valid && k < 10) begin
            @(negedge clk);
            n++;
            k++;
        end
        chk("result_time", n, 21 * (lat + 1) + 2);
        chk("out_class", out_class, exp_cls);
        chk("out_votes", out_votes, exp_votes);
        for (int h = 0; h < hold; h++) begin
            in_valid  = 1'b1;
            in_data   = ~data;
            svm_done  = (h == 1);
            svm_class = 1'b0;
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_class", out_class, exp_cls);
            chk("hold_out_votes", out_votes, exp_votes);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        svm_done  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        chk("release_inputs", svm_inputs, data);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t          tbl[4];
        logic [20:0]   rdec;
        logic [DW-1:0] rdata;
        logic [2:0]    seq3;
        int            ecls, evotes, k;

        tbl[0] = '{44'h123_4567_89AB, 21'h1FFFFF, 3, 5, 0, 6};
        tbl[1] = '{44'hFED_CBA9_8765, 21'h000000, 2, 0, 6, 6};
        tbl[2] = '{44'hA5A_5A5A_5A5A, 21'h05BBDF, 1, 2, 6, 6};
        tbl[3] = '{44'h0F0_F0F0_F0F0, 21'h1FFFFE, 4, 1, 1, 6};

        rst        = 1'b1;
        in_valid   = 1'b0; in_data   = '0; svm_done  = 1'b0;
        svm_class  = 1'b0; out_ready = 1'b0;
        in_valid3  = 1'b0; in_data3  = '0; svm_done3 = 1'b0;
        svm_class3 = 1'b0; out_ready3 = 1'b0;
        last_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_svm_start", svm_start, 0);
        chk("rst_pair_idx", svm_pair_idx, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_out_votes", out_votes, 0);
        chk("rst_svm_inputs", svm_inputs, 0);
        chk("rst3_in_ready", in_ready3, 1);
        rst = 1'b0;

        // Stray engine result while idle.
        @(negedge clk);
        svm_done  = 1'b1;
        svm_class = 1'b1;
        @(negedge clk);
        svm_done = 1'b0;
        chk("stray_idle_in_ready", in_ready, 1);
        chk("stray_idle_start", svm_start, 0);
        chk("stray_idle_out_valid", out_valid, 0);

        for (int t = 0; t < 4; t++) begin
            run7(tbl[t].data, tbl[t].dec, tbl[t].lat, tbl[t].hold, -1,
                 tbl[t].exp_cls, tbl[t].exp_votes);
        end

        // Abort in WAIT at pair 4, then a clean inference from pair 0.
        run7(44'h111_2222_3333, 21'h1FFFFF, 3, 0, 4, 0, 0);
        run7(tbl[3].data, tbl[3].dec, 2, 0, -1, 1, 6);

        // Reset and in_valid together: reset wins.
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 44'hBEE_F00D_CAFE;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        last_data = '0;
        chk("rst_vs_valid_in_ready", in_ready, 1);
        chk("rst_vs_valid_start", svm_start, 0);
        chk("rst_vs_valid_inputs", svm_inputs, 0);

        for (int r = 0; r < 6; r++) begin
            rdec  = 21'($urandom);
            rdata = {12'($urandom), $urandom};
            model(rdec, 7, ecls, evotes);
            run7(rdata, rdec, int'($urandom_range(1, 4)), r % 3, -1,
                 ecls, evotes);
        end

        // N=3 tie case.
        seq3 = 3'b101;
        @(negedge clk);
        in_valid3 = 1'b1;
        in_data3  = 44'h777_0000_1234;
        @(negedge clk);
        in_valid3 = 1'b0;
        for (int p = 0; p < 3; p++) begin
            k = 0;
            while (!svm_start3 && k < 8) begin
                @(negedge clk);
                k++;
            end
            chk("n3_start_seen", svm_start3, 1);
            chk("n3_pair_idx", svm_pair_idx3, p);
            @(negedge clk);
            svm_done3  = 1'b1;
            svm_class3 = seq3[p];
            @(negedge clk);
            svm_done3 = 1'b0;
        end
        k = 0;
        while (!out_valid3 && k < 10) begin
            @(negedge clk);
            k++;
        end
        model(21'(seq3), 3, ecls, evotes);
        chk("n3_out_valid", out_valid3, 1);
        chk("n3_out_class", out_class3, 0);
        chk("n3_out_votes", out_votes3, 1);
        chk("n3_model_class", out_class3, ecls);
        chk("n3_model_votes", out_votes3, evotes);
        out_ready3 = 1'b1;
        @(negedge clk);
        out_ready3 = 1'b0;
        chk("n3_release", out_valid3, 0);
        chk("n3_idle", in_ready3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
